// File: rtl/irq_encoder_8to3_pkg.sv
// Purpose: shared types, sizes and helpers for the 8-to-3 interrupt/request encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: state_e FSM encoding, N_REQ / IDX_W sizes, onehot_of() index-to-one-hot helper.
package irq_enc_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Decoder direction: binary index back to its one-hot line.
  function automatic logic [N_REQ-1:0] onehot_of(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/irq_encoder_8to3_if.sv
// Purpose: bundles request-side inputs and the valid/ready index output of the encoder.
// Latency: n/a (wires only).
// Backpressure: out_ready from the consumer stalls out_valid/out_idx/out_onehot.
// Ports: req_in/mask/flush/out_ready driven toward the encoder;
//        out_valid/out_idx/out_onehot/pending driven by the encoder.
interface irq_encoder_8to3_if;
  import irq_enc_pkg::*;

  logic [N_REQ-1:0] req_in;
  logic [N_REQ-1:0] mask;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [N_REQ-1:0] out_onehot;
  logic [N_REQ-1:0] pending;

  // Encoder side: produces the index stream.
  modport master (
    input  req_in,
    input  mask,
    input  flush,
    input  out_ready,
    output out_valid,
    output out_idx,
    output out_onehot,
    output pending
  );

  // Requester/consumer side.
  modport slave (
    output req_in,
    output mask,
    output flush,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  out_onehot,
    input  pending
  );

endinterface

// File: rtl/irq_encoder_8to3_prio_pick8.sv
// Purpose: combinational priority pick of one set bit out of 8 eligible lines.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows elig_i immediately.
// Ports: elig_i[7:0] eligible lines; any_o = some line eligible; idx_o = index of winner
//        (bit 7 wins when MSB_FIRST = 1, bit 0 wins when MSB_FIRST = 0; 0 when none).
module prio_pick8
  import irq_enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [N_REQ-1:0] elig_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan toward the winning end so the last hit seen is the highest-priority one.
  always_comb begin
    any_o = |elig_i;
    idx_o = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (elig_i[i]) idx_o = IDX_W'(i);
      end
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (elig_i[i]) idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_encoder_8to3.sv
// Purpose: registered 8-to-3 priority encoder with sticky request capture and valid/ready output.
// Latency: req_in sampled at edge k is presented (out_valid = 1) after edge k; one index per cycle back-to-back.
// Backpressure: while out_ready = 0 the presented index is frozen; pending keeps collecting requests.
// Ports: clk rising-edge clock; rst async active-high reset;
//        bus (master modport): req_in, mask, flush, out_ready in; out_valid, out_idx, out_onehot, pending out.
module irq_encoder_8to3
  import irq_enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  irq_encoder_8to3_if.master bus
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] pend_q,  pend_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [N_REQ-1:0] oh_q,    oh_d;

  logic             hs;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] seen;
  logic [N_REQ-1:0] elig;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  // Served bit drops on handshake unless the same line re-requests this cycle;
  // a fresh request must not be swallowed by the acknowledgement of the old one.
  always_comb begin
    hs   = (state_q == HOLD) && bus.out_ready;
    clr  = hs ? (oh_q & ~bus.req_in) : '0;
    seen = (pend_q | bus.req_in) & ~clr;
    elig = seen & ~bus.mask;
  end

  prio_pick8 #(
    .MSB_FIRST (MSB_FIRST)
  ) u_pick (
    .elig_i (elig),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = seen;
    idx_d   = idx_q;
    oh_d    = oh_q;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = HOLD;
          idx_d   = pick_idx;
          oh_d    = onehot_of(pick_idx);
        end
      end
      HOLD: begin
        // Presented index is only replaced on acceptance, never by a new winner.
        if (hs) begin
          if (pick_any) begin
            idx_d = pick_idx;
            oh_d  = onehot_of(pick_idx);
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            oh_d    = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        oh_d    = '0;
      end
    endcase

    // Flush discards everything, including requests arriving in the same cycle.
    if (bus.flush) begin
      state_d = IDLE;
      pend_d  = '0;
      idx_d   = '0;
      oh_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
      oh_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
    end
  end

  assign bus.out_valid  = (state_q == HOLD);
  assign bus.out_idx    = idx_q;
  assign bus.out_onehot = oh_q;
  assign bus.pending    = pend_q;

endmodule
